// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, word and
// length-field geometry, and the byte-order constants used to assemble words.
package loader_pkg;

  // Session states of the loader FSM.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // Byte and word geometry.
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = WORD_W / BYTE_W;
  localparam int CNT_W      = $clog2(WORD_BYTES);

  // Length field: 16-bit word count, high byte sent first.
  localparam int LEN_W      = 16;
  localparam int LEN_HI_LSB = LEN_W - BYTE_W;

  // Words arrive most-significant byte first, so each new byte enters the
  // low lane and earlier bytes move toward the top of the word.
  localparam int FIRST_LANE = 0;

endpackage

// File: rtl/byte_packer.sv
// Four-byte shift register that assembles a 32-bit word MSB first.
// word_full marks the cycle in which the fourth byte of a word is taken.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] word_next;
  logic [CNT_W-1:0]  count_reg;

  // Each lane takes the lane below it on a shift; the lowest lane takes the new byte.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      if (gi == FIRST_LANE) begin : g_first
        assign word_next[gi*BYTE_W +: BYTE_W] =
          shift_en ? byte_in : word_reg[gi*BYTE_W +: BYTE_W];
      end else begin : g_rest
        assign word_next[gi*BYTE_W +: BYTE_W] =
          shift_en ? word_reg[(gi-1)*BYTE_W +: BYTE_W] : word_reg[gi*BYTE_W +: BYTE_W];
      end
    end
  endgenerate

  // Word register; clear only resets the byte count so the last word stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_reg <= '0;
    end else begin
      word_reg <= word_next;
    end
  end

  // Byte counter within the current word; wraps after the fourth byte.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (shift_en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign word      = word_reg;
  assign word_full = shift_en && (count_reg == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: receives a 16-bit word count followed by that many
// 32-bit words over a byte handshake and writes them to instruction memory,
// holding the CPU in reset while a session is in progress.
module inst_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] datain,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  len_full;
  logic              accept;
  logic              more_words;
  logic              word_full;
  logic [WORD_W-1:0] packed_word;

  // A start pulse always wins over a byte offered in the same cycle.
  assign accept     = byte_valid && byte_ready && !start;
  assign len_full   = {len_reg[LEN_W-1:LEN_HI_LSB], byte_in};
  assign more_words = (32'(addr_reg) + 32'd1) < 32'(len_reg);

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .shift_en  (accept && (state_reg == DATA)),
    .byte_in   (byte_in),
    .word      (packed_word),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start restarts the session from any state.
  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = LEN_HI;
    end else begin
      case (state_reg)
        LEN_HI: if (accept) state_next = LEN_LO;
        LEN_LO: begin
          if (accept) begin
            if (len_full == '0)                     state_next = DONE;
            else if (32'(len_full) > 32'(DEPTH))    state_next = ERR;
            else                                    state_next = DATA;
          end
        end
        DATA:   if (word_full) state_next = WRITE;
        WRITE:  state_next = more_words ? DATA : DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  // Length capture and word address; addr only advances when another word follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg <= '0;
      len_reg  <= '0;
    end else if (start) begin
      addr_reg <= '0;
    end else begin
      case (state_reg)
        LEN_HI: if (accept) len_reg[LEN_W-1:LEN_HI_LSB] <= byte_in;
        LEN_LO: begin
          if (accept) begin
            len_reg[LEN_HI_LSB-1:0] <= byte_in;
            addr_reg                <= '0;
          end
        end
        WRITE:  if (more_words) addr_reg <= addr_reg + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    byte_ready = (state_reg == LEN_HI) || (state_reg == LEN_LO) || (state_reg == DATA);
    busy       = byte_ready || (state_reg == WRITE);
    cpu_hold   = busy;
    write      = (state_reg == WRITE);
    done       = (state_reg == DONE);
    error      = (state_reg == ERR);
    addr       = addr_reg;
    datain     = packed_word;
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader.
module tb_inst_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        write;
  logic [15:0] addr;
  logic [31:0] datain;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];

  inst_loader #(.DEPTH(256), .ADDR_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .write      (write),
    .addr       (addr),
    .datain     (datain),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      wr_addr.push_back(addr);
      wr_data.push_back(datain);
      $display("write addr=%0d data=%h", addr, datain);
    end
  end

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offer one byte and return once it has been accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!byte_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
    end
    tick();
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    byte_valid = 1'b0;
    while (!(done || error) && n < 60) begin
      tick();
      n++;
    end
    if (!(done || error)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_end_timeout: done=%b error=%b required one set", done, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
    tick(); tick();
    n_cmp++; if ({write, byte_ready, busy, done, error, cpu_hold} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000000", {write, byte_ready, busy, done, error, cpu_hold}); end
    n_cmp++; if (addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h required 0000", addr); end
    n_cmp++; if (datain !== 32'h0) begin n_fail++; $display("FAIL reset_datain: got %h required 00000000", datain); end
    reset = 1'b0; start = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_over_start: busy got %b required 0", busy); end
  endtask

  task automatic test_two_words();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    n_cmp++; if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL start_busy: busy=%b cpu_hold=%b required 1 1", busy, cpu_hold); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h60); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h60); send_byte(8'h40); send_byte(8'h00); send_byte(8'h14);
    wait_end();
    n_cmp++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL two_words_count: got %0d required 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      n_cmp++; if (wr_addr[0] !== 16'd0 || wr_data[0] !== 32'h60400000) begin
        n_fail++; $display("FAIL two_words_w0: got %h@%0d required 60400000@0", wr_data[0], wr_addr[0]); end
      n_cmp++; if (wr_addr[1] !== 16'd1 || wr_data[1] !== 32'h60400014) begin
        n_fail++; $display("FAIL two_words_w1: got %h@%0d required 60400014@1", wr_data[1], wr_addr[1]); end
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL two_words_done: done=%b busy=%b error=%b required 1 0 0", done, busy, error); end
    tick();
    n_cmp++; if (done !== 1'b1 || addr !== 16'd1) begin
      n_fail++; $display("FAIL two_words_hold: done=%b addr=%0d required 1 1", done, addr); end
  endtask

  task automatic test_zero_length();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    byte_valid = 1'b0;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_len: done=%b busy=%b byte_ready=%b required 1 0 0", done, busy, byte_ready); end
    tick();
    n_cmp++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL zero_len_writes: got %0d required 0", wr_addr.size()); end
  endtask

  task automatic test_too_long();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    n_cmp++; if (error !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL too_long: error=%b byte_ready=%b busy=%b done=%b required 1 0 0 0", error, byte_ready, busy, done); end
    for (int i = 0; i < 6; i++) begin
      byte_in = 8'hA0 + 8'(i); byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    tick();
    n_cmp++; if (error !== 1'b1 || byte_ready !== 1'b0 || wr_addr.size() !== 0 || addr !== 16'd0) begin
      n_fail++; $display("FAIL too_long_ignore: error=%b byte_ready=%b writes=%0d addr=%0d required 1 0 0 0", error, byte_ready, wr_addr.size(), addr); end
  endtask

  task automatic test_gapped_valid();
    logic [7:0] data_bytes [4];
    data_bytes[0] = 8'hAA; data_bytes[1] = 8'hBB; data_bytes[2] = 8'hCC; data_bytes[3] = 8'hDD;
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < 8; i++) begin
      byte_valid = (i % 2 == 0);
      byte_in    = (i % 2 == 0) ? data_bytes[i/2] : 8'hFF;
      tick();
    end
    wait_end();
    n_cmp++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL gapped_count: got %0d required 1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      n_cmp++; if (wr_data[0] !== 32'hAABBCCDD || wr_addr[0] !== 16'd0) begin
        n_fail++; $display("FAIL gapped_word: got %h@%0d required aabbccdd@0", wr_data[0], wr_addr[0]); end
    end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL gapped_done: got %b required 1", done); end
  endtask

  task automatic test_reset_mid_word();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({write, byte_ready, busy, done, error, cpu_hold} !== 6'b0 || addr !== 16'd0 || datain !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: flags=%b addr=%h datain=%h required 000000 0000 00000000",
                         {write, byte_ready, busy, done, error, cpu_hold}, addr, datain); end
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    wait_end();
    n_cmp++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL after_reset_count: got %0d required 1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      n_cmp++; if (wr_data[0] !== 32'h12345678 || wr_addr[0] !== 16'd0) begin
        n_fail++; $display("FAIL after_reset_word: got %h@%0d required 12345678@0", wr_data[0], wr_addr[0]); end
    end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL after_reset_done: got %b required 1", done); end
  endtask

  task automatic test_restart_mid_data();
    pulse_start();
    send_byte(8'h00); send_byte(8'h05);
    for (int w = 0; w < 3; w++) begin
      send_byte(8'h10 + 8'(w)); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    end
    byte_valid = 1'b0;
    tick();
    n_cmp++; if (addr !== 16'd3 || byte_ready !== 1'b1) begin
      n_fail++; $display("FAIL pre_restart: addr=%0d byte_ready=%b required 3 1", addr, byte_ready); end
    send_byte(8'hEE); send_byte(8'hEE);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    n_cmp++; if (addr !== 16'd0 || byte_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL restart: addr=%0d byte_ready=%b busy=%b done=%b required 0 1 1 0", addr, byte_ready, busy, done); end
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_end();
    n_cmp++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL restart_count: got %0d required 1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      n_cmp++; if (wr_data[0] !== 32'h01020304 || wr_addr[0] !== 16'd0) begin
        n_fail++; $display("FAIL restart_word: got %h@%0d required 01020304@0", wr_data[0], wr_addr[0]); end
    end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b required 1", done); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_length();
    test_too_long();
    test_gapped_valid();
    test_reset_mid_word();
    test_restart_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
